// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: request payload, response owner
// and the response-tracker entry.
package dmem_arbiter_pkg;

  typedef logic [31:0] address_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  typedef struct packed {
    logic     we;
    address_t addr;
    word_t    wdata;
    be_t      be;
  } dmem_req_t;

  typedef enum logic {
    OWNER_LS  = 1'b0,
    OWNER_AUX = 1'b1
  } dmem_owner_e;

  typedef struct packed {
    logic        valid;
    dmem_owner_e owner;
  } trk_entry_t;

  // Wide enough for the largest supported MAX_WAIT (15).
  localparam int STARVE_W = 4;

  localparam dmem_req_t REQ_IDLE = '{we: 1'b0, addr: '0, wdata: '0, be: '0};

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// Handshake: px_en is "valid", px_gnt is "accepted this cycle"; the requester
// holds px_en and its payload stable until it sees px_gnt high.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic     p0_en, p0_we;
  address_t p0_addr;
  word_t    p0_wdata;
  be_t      p0_be;
  logic     p0_gnt, p0_rvalid;
  word_t    p0_rdata;

  logic     p1_en, p1_we;
  address_t p1_addr;
  word_t    p1_wdata;
  be_t      p1_be;
  logic     p1_gnt, p1_rvalid;
  word_t    p1_rdata;

  logic     mem_en, mem_we;
  address_t mem_addr;
  word_t    mem_wdata;
  be_t      mem_be;
  word_t    mem_rdata;

  modport slave (
    input  p0_en, p0_we, p0_addr, p0_wdata, p0_be,
    input  p1_en, p1_we, p1_addr, p1_wdata, p1_be,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output p0_en, p0_we, p0_addr, p0_wdata, p0_be,
    output p1_en, p1_we, p1_addr, p1_wdata, p1_be,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/dmem_resp_tracker.sv
// Fixed-latency read tracker: a MEM_LATENCY-deep shift register of
// {valid, owner}; the last stage raises the owner's rvalid for one cycle.
module dmem_resp_tracker
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  dmem_owner_e push_owner,
  output logic        p0_rvalid,
  output logic        p1_rvalid
);

  trk_entry_t sr [MEM_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) sr[i] <= '0;
    end else begin
      sr[0] <= '{valid: push, owner: push_owner};
      for (int i = 1; i < MEM_LATENCY; i++) sr[i] <= sr[i-1];
    end
  end

  // Only one stage drains per cycle, so the two strobes are exclusive.
  assign p0_rvalid = sr[MEM_LATENCY-1].valid && (sr[MEM_LATENCY-1].owner == OWNER_LS);
  assign p1_rvalid = sr[MEM_LATENCY-1].valid && (sr[MEM_LATENCY-1].owner == OWNER_AUX);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: load/store port 0 has priority, port 1 wins a
// conflict once it has lost MAX_WAIT times in a row. Reads return in order.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int MAX_WAIT    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_arbiter_if.slave       bus,
  output logic [STARVE_W-1:0] dbg_starve_cnt
);

  localparam logic [STARVE_W-1:0] MAX_WAIT_C = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                p1_starved;
  logic                p0_gnt, p1_gnt;
  logic                p0_rvalid, p1_rvalid;
  dmem_req_t           p0_req, p1_req, sel_req;

  assign p0_req = '{we: bus.p0_we, addr: bus.p0_addr, wdata: bus.p0_wdata, be: bus.p0_be};
  assign p1_req = '{we: bus.p1_we, addr: bus.p1_addr, wdata: bus.p1_wdata, be: bus.p1_be};

  assign p1_starved = (starve_cnt == MAX_WAIT_C);

  // Grants are gated by reset so nothing reaches memory while rst_n is low.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst_n) begin
      if (bus.p0_en && !(bus.p1_en && p1_starved)) p0_gnt = 1'b1;
      else if (bus.p1_en)                          p1_gnt = 1'b1;
    end
  end

  always_comb begin
    sel_req = REQ_IDLE;
    if (p0_gnt)      sel_req = p0_req;
    else if (p1_gnt) sel_req = p1_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (p1_gnt) begin
      starve_cnt <= '0;
    end else if (bus.p1_en && !p1_starved) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  dmem_resp_tracker #(.MEM_LATENCY(MEM_LATENCY)) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.mem_en && !sel_req.we),
    .push_owner(p1_gnt ? OWNER_AUX : OWNER_LS),
    .p0_rvalid (p0_rvalid),
    .p1_rvalid (p1_rvalid)
  );

  assign bus.p0_gnt    = p0_gnt;
  assign bus.p1_gnt    = p1_gnt;
  assign bus.mem_en    = p0_gnt | p1_gnt;
  assign bus.mem_we    = sel_req.we;
  assign bus.mem_addr  = sel_req.addr;
  assign bus.mem_wdata = sel_req.wdata;
  assign bus.mem_be    = sel_req.be;

  assign bus.p0_rvalid = p0_rvalid;
  assign bus.p1_rvalid = p1_rvalid;
  assign bus.p0_rdata  = p0_rvalid ? bus.mem_rdata : '0;
  assign bus.p1_rdata  = p1_rvalid ? bus.mem_rdata : '0;

  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then randomized traffic, all
// checked against a cycle-indexed reference model of grants and responses.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int LAT  = 2;
  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dbg_starve;

  dmem_arbiter_if bus();

  dmem_arbiter #(.MEM_LATENCY(LAT), .MAX_WAIT(MAXW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .dbg_starve_cnt(dbg_starve)
  );

  always #5 clk = ~clk;

  // Outstanding reads: response due in absolute cycle 'due' for 'owner'.
  typedef struct {
    int          due;
    int          owner;
    logic [31:0] addr;
  } rd_t;

  rd_t  exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_starve = 0;
  logic g_last0 = 1'b0;
  logic g_last1 = 1'b0;

  function automatic logic [31:0] data_of(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEADBEEF;
    return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic en, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    if (port == 0) begin
      bus.p0_en = en; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_be = be;
    end else begin
      bus.p1_en = en; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_be = be;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // One cycle: called in the low clock phase with inputs already applied.
  task automatic step();
    logic        e0, e1, g0, g1, ewe, v0, v1;
    logic [31:0] ea, ew, er0, er1;
    logic [3:0]  ebe;
    rd_t         r;
    if (!rst_n) begin
      exp_q.delete();
      m_starve = 0;
    end
    v0 = 1'b0; v1 = 1'b0; er0 = '0; er1 = '0;
    bus.mem_rdata = $urandom;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      bus.mem_rdata = data_of(r.addr);
      if (r.owner == 0) begin v0 = 1'b1; er0 = data_of(r.addr); end
      else              begin v1 = 1'b1; er1 = data_of(r.addr); end
    end
    e0 = rst_n && bus.p0_en;
    e1 = rst_n && bus.p1_en;
    g1 = e1 && (!e0 || m_starve == MAXW);
    g0 = e0 && !g1;
    ewe = 1'b0; ea = '0; ew = '0; ebe = '0;
    if (g0) begin ewe = bus.p0_we; ea = bus.p0_addr; ew = bus.p0_wdata; ebe = bus.p0_be; end
    if (g1) begin ewe = bus.p1_we; ea = bus.p1_addr; ew = bus.p1_wdata; ebe = bus.p1_be; end
    #1;
    check("p0_gnt",    32'(bus.p0_gnt),    32'(g0));
    check("p1_gnt",    32'(bus.p1_gnt),    32'(g1));
    check("mem_en",    32'(bus.mem_en),    32'(g0 | g1));
    check("mem_we",    32'(bus.mem_we),    32'(ewe));
    check("mem_addr",  bus.mem_addr,       ea);
    check("mem_wdata", bus.mem_wdata,      ew);
    check("mem_be",    32'(bus.mem_be),    32'(ebe));
    check("p0_rvalid", 32'(bus.p0_rvalid), 32'(v0));
    check("p1_rvalid", 32'(bus.p1_rvalid), 32'(v1));
    check("p0_rdata",  bus.p0_rdata,       er0);
    check("p1_rdata",  bus.p1_rdata,       er1);
    check("starve",    32'(dbg_starve),    32'(m_starve));
    if (rst_n) begin
      if (g1) m_starve = 0;
      else if (e1 && m_starve < MAXW) m_starve++;
      if ((g0 || g1) && !ewe) exp_q.push_back('{due: cyc + LAT, owner: (g1 ? 1 : 0), addr: ea});
    end
    g_last0 = g0;
    g_last1 = g1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    idle();
    bus.mem_rdata = '0;
    rst_n = 1'b0;
    @(negedge clk);
    // Reset with requests pending: everything must stay quiet.
    drive(0, 1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b1, 32'h88, 32'h1234, 4'hF);
    repeat (3) step();
    idle();
    rst_n = 1'b1;
    step();

    // Single read from port 0.
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    step();
    idle();
    repeat (4) step();

    // Sustained conflict: port 1 breaks through after MAX_WAIT losses.
    drive(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    repeat (6) step();
    idle();
    repeat (4) step();

    // Alternating owners, back-to-back reads.
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF); step(); idle();
    drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF); step(); idle();
    drive(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF); step(); idle();
    repeat (4) step();

    // Port 1 partial write: no read response.
    drive(1, 1'b1, 1'b1, 32'h40, 32'h55AA55AA, 4'h3);
    step();
    idle();
    repeat (4) step();

    // Read in flight, then a one-cycle reset pulse kills it.
    drive(0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    step();
    drive(0, 1'b1, 1'b0, 32'h504, 32'h0, 4'hF);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    idle();
    repeat (4) step();

    // Randomized traffic with held requests and rare resets.
    for (int k = 0; k < 400; k++) begin
      if (!bus.p0_en || g_last0) begin
        if ($urandom_range(0, 1) == 1)
          drive(0, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
        else
          drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      if (!bus.p1_en || g_last1) begin
        if ($urandom_range(0, 2) != 0)
          drive(1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
        else
          drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      rst_n = ($urandom_range(0, 79) != 0);
      step();
    end
    rst_n = 1'b1;
    idle();
    repeat (LAT + 2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 2, fixed cycles from accepted read to valid mem_rdata (range 1..4).
REQ-002 Parameter MAX_WAIT, default 4, consecutive lost conflicts after which port 1 wins (range 1..15).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 p0_en / p0_we  in  1/1  load/store port: request valid / write (0 = read).
REQ-006 p0_addr / p0_wdata / p0_be  in  32/32/4  load/store address, write data, byte enables.
REQ-007 p0_gnt  out  1  port 0 request accepted this cycle.
REQ-008 p0_rvalid / p0_rdata  out  1/32  port 0 read response.
REQ-009 p1_en, p1_we, p1_addr, p1_wdata, p1_be, p1_gnt, p1_rvalid, p1_rdata  same widths and meaning as port 0, for the secondary requester (debug/DMA).
REQ-010 mem_en / mem_we  out  1/1  memory access strobe / write.
REQ-011 mem_addr / mem_wdata / mem_be  out  32/32/4  memory address, write data, byte enables.
REQ-012 mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after a read strobe.

Function
REQ-013 Grant is combinational: px_gnt high in the cycle of acceptance; requester holds px_en and payload stable until px_gnt.
REQ-014 At most one of p0_gnt, p1_gnt high per cycle; grant only to a port with px_en high.
REQ-015 Single request: requesting port granted in the same cycle.
REQ-016 Conflict (both en): port 0 wins unless starve_cnt == MAX_WAIT, then port 1 wins.
REQ-017 starve_cnt: +1 on a cycle where p1_en high and p1_gnt low; saturates at MAX_WAIT; clears to 0 on p1_gnt; holds otherwise.
REQ-018 mem_en = p0_gnt | p1_gnt; mem_we/addr/wdata/be muxed from the granted port; all zero when no grant.
REQ-019 Read grant sets a tracker entry {valid, owner}; owner's px_rvalid high exactly MEM_LATENCY cycles later, for one cycle.
REQ-020 Writes produce no rvalid.
REQ-021 px_rdata = mem_rdata when px_rvalid high, else 0.
REQ-022 Back-to-back reads, including alternating owners, are pipelined: one response per cycle, order preserved.
REQ-023 p0_rvalid and p1_rvalid never high in the same cycle.

Reset
REQ-024 While reset low: p0_gnt, p1_gnt, mem_en, mem_we, p0_rvalid, p1_rvalid are 0; mem_addr, mem_wdata, mem_be, p0_rdata, p1_rdata are 0.
REQ-025 Reset assertion clears starve_cnt and all tracker entries asynchronously.
REQ-026 Reads in flight at reset assertion produce no rvalid after reset release.
REQ-027 First grant is possible in the first rising edge after reset release.

Structure
REQ-028 Address and Word types come from Pu_types; new typedef Dmem_req (we, addr, wdata, be) and enum Dmem_owner (OWNER_LS, OWNER_AUX) go in Backend.
REQ-029 One sub-module dmem_resp_tracker: MEM_LATENCY-deep shift register of {valid, owner}, async active-low reset, outputs the two rvalid strobes.
REQ-030 Arbitration, starvation counter and request mux stay in dmem_arbiter.

Verification (MEM_LATENCY=2, MAX_WAIT=4)
REQ-031 p0 read addr 0x100, p1 idle; mem_rdata=0xDEADBEEF at T+2 -> p0_gnt at T, mem_addr=0x100, p0_rvalid/p0_rdata=0xDEADBEEF at T+2 only.
REQ-032 p0 and p1 both request continuously for 6 cycles -> p0 granted cycles 0-3, p1 granted cycle 4, starve_cnt 0 in cycle 5, p0 granted cycle 5.
REQ-033 Alternating reads p0@0x10, p1@0x20, p0@0x30 in consecutive cycles -> rvalid on p0, p1, p0 in cycles 2, 3, 4 with matching data.
REQ-034 p1 write 0x55AA55AA, be=0x3 @0x40 -> mem_we=1, mem_be=0x3, no rvalid on either port in the following 4 cycles.
REQ-035 p0 read granted, reset pulsed low 1 cycle later -> all outputs 0 during reset, no p0_rvalid after release, p0_gnt available on the next edge.
